// File: rtl/axi_traffic_sequencer.sv
// Single-outstanding AXI4 handshake sequencer: runs `count` writes then `count` reads,
// checks responses and abandons the run if the bus stalls for TIMEOUT cycles.
//
// state     | meaning
// IDLE      | waiting for start
// WR_ISSUE  | awvalid/wvalid offered, each drops on its own handshake
// WR_RESP   | bready high, waiting for B
// RD_ISSUE  | arvalid offered
// RD_DATA   | rready high, waiting for R
// FINISH    | done pulse, back to IDLE next cycle
module axi_traffic_sequencer #(
    parameter int CW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          do_write,
    input  logic          do_read,
    input  logic [CW-1:0] count,
    input  logic          awready,
    input  logic          wready,
    input  logic          arready,
    input  logic          bvalid,
    input  logic [1:0]    bresp,
    input  logic          rvalid,
    input  logic [1:0]    rresp,
    input  logic          rlast,
    output logic          awvalid,
    output logic          wvalid,
    output logic          bready,
    output logic          arvalid,
    output logic          rready,
    output logic          busy,
    output logic          done,
    output logic          bresp_err,
    output logic          rresp_err,
    output logic          rlast_err,
    output logic          timeout_err,
    output logic [CW-1:0] wr_completed,
    output logic [CW-1:0] rd_completed
);

    localparam int SW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_DATA,
        ST_FINISH
    } state_t;

    state_t          r_state;
    logic            r_do_read;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_stall;
    logic            r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic            r_busy, r_done;
    logic            r_bresp_err, r_rresp_err, r_rlast_err, r_timeout_err;
    logic [CW-1:0]   r_wr_cnt, r_rd_cnt;

    logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_hs;
    logic            w_in_xfer, w_abort, w_cnt_nz;
    logic [CW-1:0]   w_wr_next, w_rd_next;

    assign w_aw_hs   = r_awvalid & awready;
    assign w_w_hs    = r_wvalid  & wready;
    assign w_b_hs    = r_bready  & bvalid;
    assign w_ar_hs   = r_arvalid & arready;
    assign w_r_hs    = r_rready  & rvalid;
    assign w_hs      = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign w_in_xfer = (r_state == ST_WR_ISSUE) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_ISSUE) || (r_state == ST_RD_DATA);
    // A handshake on the stall edge counts as progress and beats the watchdog.
    assign w_abort   = w_in_xfer && !w_hs && (r_stall == STALL_MAX);
    assign w_cnt_nz  = (count != '0);
    assign w_wr_next = r_wr_cnt + CW'(1);
    assign w_rd_next = r_rd_cnt + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_do_read     <= 1'b0;
            r_count       <= '0;
            r_stall       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bresp_err   <= 1'b0;
            r_rresp_err   <= 1'b0;
            r_rlast_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_hs || !w_in_xfer) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + SW'(1);
            end

            if (w_abort) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_timeout_err <= 1'b1;
                r_done        <= 1'b1;
                r_state       <= ST_FINISH;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_do_read     <= do_read;
                            r_count       <= count;
                            r_busy        <= 1'b1;
                            r_wr_cnt      <= '0;
                            r_rd_cnt      <= '0;
                            r_bresp_err   <= 1'b0;
                            r_rresp_err   <= 1'b0;
                            r_rlast_err   <= 1'b0;
                            r_timeout_err <= 1'b0;
                            if (do_write && w_cnt_nz) begin
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= ST_WR_ISSUE;
                            end else if (do_read && w_cnt_nz) begin
                                r_arvalid <= 1'b1;
                                r_state   <= ST_RD_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end

                    ST_WR_ISSUE: begin
                        if (w_aw_hs) r_awvalid <= 1'b0;
                        if (w_w_hs)  r_wvalid  <= 1'b0;
                        if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_WR_RESP;
                        end
                    end

                    ST_WR_RESP: begin
                        if (w_b_hs) begin
                            r_wr_cnt <= w_wr_next;
                            r_bready <= 1'b0;
                            if (bresp != 2'b00) r_bresp_err <= 1'b1;
                            if (w_wr_next != r_count) begin
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= ST_WR_ISSUE;
                            end else if (r_do_read) begin
                                r_arvalid <= 1'b1;
                                r_state   <= ST_RD_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end

                    ST_RD_ISSUE: begin
                        if (w_ar_hs) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= ST_RD_DATA;
                        end
                    end

                    ST_RD_DATA: begin
                        if (w_r_hs) begin
                            r_rd_cnt <= w_rd_next;
                            r_rready <= 1'b0;
                            if (rresp != 2'b00) r_rresp_err <= 1'b1;
                            if (!rlast)         r_rlast_err <= 1'b1;
                            if (w_rd_next != r_count) begin
                                r_arvalid <= 1'b1;
                                r_state   <= ST_RD_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end

                    ST_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign awvalid      = r_awvalid;
    assign wvalid       = r_wvalid;
    assign bready       = r_bready;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bresp_err    = r_bresp_err;
    assign rresp_err    = r_rresp_err;
    assign rlast_err    = r_rlast_err;
    assign timeout_err  = r_timeout_err;
    assign wr_completed = r_wr_cnt;
    assign rd_completed = r_rd_cnt;

endmodule

// File: tb/tb_axi_traffic_sequencer.sv
// Bench for axi_traffic_sequencer: directed scenarios plus randomized bus traffic,
// compared every cycle against a transaction-level model kept here.
module tb_axi_traffic_sequencer;

    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0, do_write = 1'b0, do_read = 1'b0;
    logic [CW-1:0] count = '0;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic          bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b1;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;

    logic          awvalid, wvalid, bready, arvalid, rready, busy, done;
    logic          bresp_err, rresp_err, rlast_err, timeout_err;
    logic [CW-1:0] wr_completed, rd_completed;

    int checks = 0;
    int errors = 0;

    axi_traffic_sequencer #(.CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .do_write(do_write), .do_read(do_read),
        .count(count), .awready(awready), .wready(wready), .arready(arready),
        .bvalid(bvalid), .bresp(bresp), .rvalid(rvalid), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .wvalid(wvalid), .bready(bready), .arvalid(arvalid), .rready(rready),
        .busy(busy), .done(done), .bresp_err(bresp_err), .rresp_err(rresp_err),
        .rlast_err(rlast_err), .timeout_err(timeout_err),
        .wr_completed(wr_completed), .rd_completed(rd_completed)
    );

    always #5 clk = ~clk;

    // Reference model: pending-offer flags plus remaining transaction counts.
    bit m_aw, m_w, m_b, m_ar, m_r, m_busy, m_done;
    bit m_berr, m_rerr, m_lerr, m_terr;
    int m_wr_cnt, m_rd_cnt, m_wr_left, m_rd_left, m_stall;

    task automatic m_reset();
        m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0; m_busy = 0; m_done = 0;
        m_berr = 0; m_rerr = 0; m_lerr = 0; m_terr = 0;
        m_wr_cnt = 0; m_rd_cnt = 0; m_wr_left = 0; m_rd_left = 0; m_stall = 0;
    endtask

    task automatic m_next_txn();
        if (m_wr_left > 0) begin
            m_aw = 1; m_w = 1;
        end else if (m_rd_left > 0) begin
            m_ar = 1;
        end else begin
            m_done = 1;
        end
    endtask

    task automatic m_step();
        bit hs;
        if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_wr_cnt = 0; m_rd_cnt = 0;
                m_berr = 0; m_rerr = 0; m_lerr = 0; m_terr = 0;
                m_busy = 1; m_stall = 0;
                m_wr_left = do_write ? int'(count) : 0;
                m_rd_left = do_read ? int'(count) : 0;
                m_next_txn();
            end
        end else begin
            hs = (m_aw && awready) || (m_w && wready) || (m_b && bvalid) ||
                 (m_ar && arready) || (m_r && rvalid);
            if (!hs && m_stall == TO - 1) begin
                m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
                m_terr = 1; m_done = 1; m_stall = 0;
            end else begin
                m_stall = hs ? 0 : m_stall + 1;
                if (m_aw || m_w) begin
                    m_aw = m_aw && !awready;
                    m_w  = m_w && !wready;
                    if (!m_aw && !m_w) m_b = 1;
                end else if (m_b) begin
                    if (bvalid) begin
                        m_wr_cnt++;
                        m_wr_left--;
                        if (bresp != 0) m_berr = 1;
                        m_b = 0;
                        m_next_txn();
                    end
                end else if (m_ar) begin
                    if (arready) begin
                        m_ar = 0;
                        m_r = 1;
                    end
                end else if (m_r && rvalid) begin
                    m_rd_cnt++;
                    m_rd_left--;
                    if (rresp != 0) m_rerr = 1;
                    if (!rlast) m_lerr = 1;
                    m_r = 0;
                    m_next_txn();
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) m_reset();
            else m_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("awvalid", 32'(awvalid), 32'(m_aw));
            chk("wvalid", 32'(wvalid), 32'(m_w));
            chk("bready", 32'(bready), 32'(m_b));
            chk("arvalid", 32'(arvalid), 32'(m_ar));
            chk("rready", 32'(rready), 32'(m_r));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("bresp_err", 32'(bresp_err), 32'(m_berr));
            chk("rresp_err", 32'(rresp_err), 32'(m_rerr));
            chk("rlast_err", 32'(rlast_err), 32'(m_lerr));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("wr_completed", 32'(wr_completed), 32'(m_wr_cnt));
            chk("rd_completed", 32'(rd_completed), 32'(m_rd_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic readies_high();
        awready = 1; wready = 1; arready = 1; bvalid = 1; rvalid = 1;
        bresp = 0; rresp = 0; rlast = 1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    bit hang;

    initial begin
        repeat (3) tick();
        resetn = 1;
        tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_counters", 32'({wr_completed, rd_completed}), 0);

        // Clean run: 4 writes x 2 cycles + 4 reads x 2 cycles, done in cycle 17
        readies_high();
        do_write = 1; do_read = 1; count = 4;
        start = 1; tick(); start = 0;
        wait_done(cyc);
        chk("clean_done_cycle", cyc, 17);
        chk("clean_wr", 32'(wr_completed), 4);
        chk("clean_rd", 32'(rd_completed), 4);
        chk("clean_errs", 32'({bresp_err, rresp_err, rlast_err, timeout_err}), 0);
        tick();
        chk("clean_busy_after", 32'(busy), 0);
        chk("clean_done_after", 32'(done), 0);

        // Skewed AW/W acceptance
        awready = 0; wready = 0; bvalid = 0;
        do_write = 1; do_read = 0; count = 1;
        start = 1; tick(); start = 0;
        chk("skew_c1_valids", 32'({awvalid, wvalid}), 32'b11);
        tick();
        awready = 1;
        tick();
        awready = 0;
        chk("skew_c3_aw", 32'(awvalid), 0);
        chk("skew_c3_w", 32'(wvalid), 1);
        chk("skew_c3_bready", 32'(bready), 0);
        tick();
        chk("skew_c4_aw", 32'(awvalid), 0);
        tick();
        wready = 1;
        tick();
        wready = 0;
        chk("skew_c6_w", 32'(wvalid), 0);
        chk("skew_c6_bready", 32'(bready), 1);
        chk("skew_c6_aw", 32'(awvalid), 0);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("skew_done", 32'(done), 1);
        chk("skew_wr", 32'(wr_completed), 1);
        tick();

        // Error responses: bresp=2 on write 2, rlast=0 on read 3
        readies_high();
        do_write = 1; do_read = 1; count = 3;
        start = 1; tick(); start = 0;
        cyc = 1;
        while (!done && cyc < 100) begin
            bresp = (m_wr_cnt == 1) ? 2'd2 : 2'd0;
            rlast = (m_rd_cnt == 2) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        chk("err_done_cycle", cyc, 13);
        chk("err_bresp", 32'(bresp_err), 1);
        chk("err_rlast", 32'(rlast_err), 1);
        chk("err_rresp", 32'(rresp_err), 0);
        chk("err_counts", 32'({wr_completed, rd_completed}), 32'h0003_0003);
        readies_high();
        tick();

        // Watchdog: arready stuck low
        arready = 0;
        do_write = 0; do_read = 1; count = 2;
        start = 1; tick(); start = 0;
        chk("wd_arvalid_on", 32'(arvalid), 1);
        wait_done(cyc);
        chk("wd_done_cycle", cyc, 17);
        chk("wd_arvalid_off", 32'(arvalid), 0);
        chk("wd_timeout_err", 32'(timeout_err), 1);
        tick();
        chk("wd_busy_after", 32'(busy), 0);
        arready = 1;

        // Zero count
        do_write = 1; do_read = 1; count = 0;
        start = 1; tick(); start = 0;
        chk("zero_done", 32'(done), 1);
        chk("zero_valids", 32'({awvalid, wvalid, arvalid}), 0);
        chk("zero_timeout_cleared", 32'(timeout_err), 0);
        tick();
        chk("zero_idle", 32'({busy, done}), 0);

        // Asynchronous reset mid-write
        count = 8;
        start = 1; tick(); start = 0;
        tick(); tick();
        chk("pre_reset_aw", 32'(awvalid), 1);
        resetn = 0;
        #1;
        chk("async_reset_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
        chk("async_reset_status", 32'({busy, done, wr_completed}), 0);
        tick(); tick();
        resetn = 1;
        tick();
        count = 2;
        start = 1; tick(); start = 0;
        wait_done(cyc);
        chk("post_reset_done_cycle", cyc, 9);
        chk("post_reset_counts", 32'({wr_completed, rd_completed}), 32'h0002_0002);
        tick();

        // Randomized traffic, including stalls long enough to trip the watchdog
        hang = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) hang = ($urandom_range(0, 7) == 0);
            awready  = !hang && ($urandom_range(0, 3) != 0);
            wready   = !hang && ($urandom_range(0, 3) != 0);
            arready  = !hang && ($urandom_range(0, 3) != 0);
            bvalid   = !hang && ($urandom_range(0, 2) != 0);
            rvalid   = !hang && ($urandom_range(0, 2) != 0);
            bresp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rresp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rlast    = ($urandom_range(0, 9) != 0);
            start    = ($urandom_range(0, 5) == 0);
            do_write = 1'($urandom_range(0, 1));
            do_read  = 1'($urandom_range(0, 1));
            count    = CW'($urandom_range(0, 5));
            if (i % 1000 == 999) resetn = 0;
            else resetn = 1;
            tick();
        end
        resetn = 1;
        start = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
